// File: rtl/sched_pkg.sv
// Shared types and elaboration helpers for the pending request scheduler.
package sched_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } out_state_t;

   localparam string PRIO_HIGH = "HIGH";
   localparam string PRIO_LOW  = "LOW";

   function automatic int unsigned idx_w(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   // Start the rotation so the first round-robin pick matches the fixed-priority pick.
   function automatic int unsigned last_idx_reset(input int unsigned width, input bit lsb_high);
      return lsb_high ? width - 1 : 0;
   endfunction

endpackage

// File: rtl/pending_request_scheduler_encoder.sv
// Combinational priority encoder: picks the lowest (LSB_HIGH=1) or highest set request bit.
module pending_request_scheduler_encoder
   import sched_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter bit          LSB_HIGH = 1'b1
) (
   input  logic [WIDTH-1:0]        req,
   output logic                    valid,
   output logic [idx_w(WIDTH)-1:0] index,
   output logic [WIDTH-1:0]        onehot
);

   localparam int unsigned IW = idx_w(WIDTH);

   // Later loop iterations overwrite earlier ones, so the scan order sets the winner.
   always_comb begin
      valid  = |req;
      index  = '0;
      onehot = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (LSB_HIGH) begin
            if (req[IW'(WIDTH - 1 - i)]) index = IW'(WIDTH - 1 - i);
         end else begin
            if (req[IW'(i)]) index = IW'(i);
         end
      end
      if (valid) onehot[index] = 1'b1;
   end

endmodule

// File: rtl/pending_request_scheduler.sv
// Sticky pending bitmap served one request at a time through a registered valid/ready grant port.
module pending_request_scheduler
   import sched_pkg::*;
#(
   parameter int unsigned WIDTH        = 4,
   parameter string       LSB_PRIORITY = "HIGH",
   parameter bit          ROUND_ROBIN  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   input  logic [WIDTH-1:0]        req_vector,
   input  logic                    flush,
   output logic                    grant_valid,
   input  logic                    grant_ready,
   output logic [idx_w(WIDTH)-1:0] grant_index,
   output logic [WIDTH-1:0]        grant_onehot,
   output logic [WIDTH-1:0]        pending,
   output logic                    busy
);

   localparam int unsigned     IW       = idx_w(WIDTH);
   localparam bit              LSB_HIGH = (LSB_PRIORITY == PRIO_HIGH);
   localparam logic [IW-1:0]   LAST_RST = IW'(last_idx_reset(WIDTH, LSB_HIGH));

   if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
      $error("pending_request_scheduler: WIDTH must be a power of two >= 2");
   end
   if (LSB_PRIORITY != PRIO_HIGH && LSB_PRIORITY != PRIO_LOW) begin : g_prio_check
      $error("pending_request_scheduler: LSB_PRIORITY must be \"HIGH\" or \"LOW\"");
   end

   out_state_t        state, state_next;
   logic              load;
   logic              take;
   logic [WIDTH-1:0]  cand;
   logic [WIDTH-1:0]  clr;
   logic [WIDTH-1:0]  pending_next;
   logic              pick_valid;
   logic [IW-1:0]     un_idx, pick_idx;
   logic [WIDTH-1:0]  un_onehot, pick_onehot;

   assign cand = pending;

   pending_request_scheduler_encoder #(
      .WIDTH    (WIDTH),
      .LSB_HIGH (LSB_HIGH)
   ) u_enc_unmasked (
      .req    (cand),
      .valid  (pick_valid),
      .index  (un_idx),
      .onehot (un_onehot)
   );

   if (ROUND_ROBIN) begin : g_rr
      logic [IW-1:0]    last_idx;
      logic [WIDTH-1:0] rr_mask;
      logic             masked_valid;
      logic [IW-1:0]    masked_idx;
      logic [WIDTH-1:0] masked_onehot;

      // Only indices past the last grant (in scan direction) are eligible first.
      always_comb begin
         rr_mask = '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (LSB_HIGH) rr_mask[IW'(i)] = (IW'(i) > last_idx);
            else          rr_mask[IW'(i)] = (IW'(i) < last_idx);
         end
      end

      pending_request_scheduler_encoder #(
         .WIDTH    (WIDTH),
         .LSB_HIGH (LSB_HIGH)
      ) u_enc_masked (
         .req    (cand & rr_mask),
         .valid  (masked_valid),
         .index  (masked_idx),
         .onehot (masked_onehot)
      );

      assign pick_idx    = masked_valid ? masked_idx    : un_idx;
      assign pick_onehot = masked_valid ? masked_onehot : un_onehot;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)    last_idx <= LAST_RST;
         else if (take) last_idx <= pick_idx;
      end
   end else begin : g_fixed
      assign pick_idx    = un_idx;
      assign pick_onehot = un_onehot;
   end

   // Output register FSM: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush)     state_next = EMPTY;
      else if (load) state_next = pick_valid ? HOLD : EMPTY;
   end

   always_comb begin
      grant_valid = (state == HOLD);
      load        = (state == EMPTY) || grant_ready;
   end

   assign take = load && pick_valid && !flush;
   assign clr  = take ? pick_onehot : '0;

   // Set is ORed in after the clear so a re-request of the granted bit survives.
   always_comb begin
      pending_next = (pending & ~clr) | (req_valid ? req_vector : '0);
      if (flush) pending_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_index  <= '0;
         grant_onehot <= '0;
      end else if (flush) begin
         grant_onehot <= '0;
      end else if (load) begin
         if (pick_valid) begin
            grant_index  <= pick_idx;
            grant_onehot <= pick_onehot;
         end else begin
            grant_onehot <= '0;
         end
      end
   end

   assign busy = grant_valid | (|pending);

endmodule

// File: tb/tb_pending_request_scheduler.sv
// Scoreboard bench: fixed-priority, round-robin (HIGH and LOW) instances on shared stimulus.
module tb_pending_request_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [3:0] req_vector = '0;
   logic       flush = 1'b0;
   logic       grant_ready = 1'b0;

   logic       gv, rr_gv, rrl_gv;
   logic [1:0] gi, rr_gi, rrl_gi;
   logic [3:0] go, rr_go, rrl_go;
   logic [3:0] pend, rr_pend, rrl_pend;
   logic       busy, rr_busy, rrl_busy;

   int total = 0;
   int bad   = 0;

   logic [1:0] exp_q[$];
   logic [1:0] exp_rr_q[$];
   logic [1:0] exp_rrl_q[$];

   always #5 clk = ~clk;

   pending_request_scheduler #(.WIDTH(4), .LSB_PRIORITY("HIGH"), .ROUND_ROBIN(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vector(req_vector), .flush(flush),
      .grant_valid(gv), .grant_ready(grant_ready), .grant_index(gi), .grant_onehot(go),
      .pending(pend), .busy(busy));

   pending_request_scheduler #(.WIDTH(4), .LSB_PRIORITY("HIGH"), .ROUND_ROBIN(1'b1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vector(req_vector), .flush(flush),
      .grant_valid(rr_gv), .grant_ready(grant_ready), .grant_index(rr_gi), .grant_onehot(rr_go),
      .pending(rr_pend), .busy(rr_busy));

   pending_request_scheduler #(.WIDTH(4), .LSB_PRIORITY("LOW"), .ROUND_ROBIN(1'b1)) dut_rrl (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vector(req_vector), .flush(flush),
      .grant_valid(rrl_gv), .grant_ready(grant_ready), .grant_index(rrl_gi), .grant_onehot(rrl_go),
      .pending(rrl_pend), .busy(rrl_busy));

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 1'b1; req_vector = 4'hF; grant_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({gv, gi, go, pend, busy} !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs got gv=%b idx=%0d onehot=%b pending=%b busy=%b want all 0",
                  gv, gi, go, pend, busy);
      end
      req_valid = 1'b0; req_vector = '0; rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         total++;
         if (gv !== 1'b0 || pend !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle got gv=%b pending=%b want gv=0 pending=0000", gv, pend);
         end
      end
   endtask

   task automatic test_fixed_priority;
      logic [1:0] e;
      @(negedge clk);
      req_valid = 1'b1; req_vector = 4'b1010; grant_ready = 1'b1;
      exp_q.push_back(2'd1); exp_q.push_back(2'd3);
      @(negedge clk);
      req_valid = 1'b0; req_vector = '0;
      total++;
      if (gv !== 1'b0 || pend !== 4'b1010) begin
         bad++;
         $display("FAIL fixed_latency got gv=%b pending=%b want gv=0 pending=1010", gv, pend);
      end
      for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
         @(negedge clk);
         total++;
         if (gv !== 1'b1) begin
            bad++;
            $display("FAIL fixed_grant_gap got gv=%b want 1 at step %0d", gv, c);
         end else begin
            e = exp_q.pop_front();
            if (gi !== e || go !== (4'b0001 << e)) begin
               bad++;
               $display("FAIL fixed_grant got idx=%0d onehot=%b want idx=%0d onehot=%b",
                        gi, go, e, 4'b0001 << e);
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL fixed_timeout got %0d grants outstanding want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      total++;
      if (gv !== 1'b0 || busy !== 1'b0 || go !== 4'b0000) begin
         bad++;
         $display("FAIL fixed_drained got gv=%b busy=%b onehot=%b want 0 0 0000", gv, busy, go);
      end
   endtask

   task automatic test_backpressure;
      logic [1:0] e;
      @(negedge clk);
      grant_ready = 1'b0; req_valid = 1'b1; req_vector = 4'b0110;
      exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      @(negedge clk);
      req_valid = 1'b0; req_vector = '0;
      repeat (5) begin
         @(negedge clk);
         total++;
         if (gv !== 1'b1 || gi !== exp_q[0] || go !== (4'b0001 << exp_q[0]) || pend !== 4'b0100) begin
            bad++;
            $display("FAIL bp_hold got gv=%b idx=%0d onehot=%b pending=%b want 1 %0d pending=0100",
                     gv, gi, go, pend, exp_q[0]);
         end
      end
      void'(exp_q.pop_front());
      grant_ready = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gv !== 1'b1 || gi !== e || pend !== 4'b0000) begin
         bad++;
         $display("FAIL bp_release got gv=%b idx=%0d pending=%b want 1 %0d 0000", gv, gi, pend, e);
      end
      @(negedge clk);
      total++;
      if (gv !== 1'b0) begin
         bad++;
         $display("FAIL bp_drained got gv=%b want 0", gv);
      end
   endtask

   task automatic test_collision;
      logic [1:0] e;
      @(negedge clk);
      grant_ready = 1'b1; req_valid = 1'b1; req_vector = 4'b0010;
      exp_q.push_back(2'd1); exp_q.push_back(2'd1);
      @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_vector = '0;
      e = exp_q.pop_front();
      total++;
      if (gv !== 1'b1 || gi !== e || pend !== 4'b0010) begin
         bad++;
         $display("FAIL collision_first got gv=%b idx=%0d pending=%b want 1 %0d 0010", gv, gi, pend, e);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gv !== 1'b1 || gi !== e || pend !== 4'b0000) begin
         bad++;
         $display("FAIL collision_regrant got gv=%b idx=%0d pending=%b want 1 %0d 0000", gv, gi, pend, e);
      end
      @(negedge clk);
      total++;
      if (gv !== 1'b0) begin
         bad++;
         $display("FAIL collision_drained got gv=%b want 0", gv);
      end
   endtask

   task automatic test_round_robin;
      logic [1:0] e;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int unsigned k = 0; k < 8; k++) begin
         exp_rr_q.push_back(2'(k));
         exp_rrl_q.push_back(2'(3 - (k % 4)));
      end
      req_valid = 1'b1; req_vector = 4'hF; grant_ready = 1'b1;
      for (int c = 0; c < 20 && (exp_rr_q.size() != 0 || exp_rrl_q.size() != 0); c++) begin
         @(negedge clk);
         if (rr_gv === 1'b1 && exp_rr_q.size() != 0) begin
            e = exp_rr_q.pop_front();
            total++;
            if (rr_gi !== e || rr_go !== (4'b0001 << e)) begin
               bad++;
               $display("FAIL rr_high got idx=%0d onehot=%b want idx=%0d", rr_gi, rr_go, e);
            end
         end
         if (rrl_gv === 1'b1 && exp_rrl_q.size() != 0) begin
            e = exp_rrl_q.pop_front();
            total++;
            if (rrl_gi !== e || rrl_go !== (4'b0001 << e)) begin
               bad++;
               $display("FAIL rr_low got idx=%0d onehot=%b want idx=%0d", rrl_gi, rrl_go, e);
            end
         end
      end
      total++;
      if (exp_rr_q.size() != 0 || exp_rrl_q.size() != 0) begin
         bad++;
         $display("FAIL rr_timeout got outstanding high=%0d low=%0d want 0 0",
                  exp_rr_q.size(), exp_rrl_q.size());
         exp_rr_q.delete(); exp_rrl_q.delete();
      end
      req_valid = 1'b0; req_vector = '0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_flush;
      logic [1:0] e;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      grant_ready = 1'b0; req_valid = 1'b1; req_vector = 4'b1100;
      exp_q.push_back(2'd2);
      @(negedge clk);
      req_valid = 1'b0; req_vector = '0;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (gv !== 1'b1 || gi !== e || pend !== 4'b1000) begin
         bad++;
         $display("FAIL flush_setup got gv=%b idx=%0d pending=%b want 1 %0d 1000", gv, gi, pend, e);
      end
      flush = 1'b1; req_valid = 1'b1; req_vector = 4'b0001; grant_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0; req_vector = '0;
      total++;
      if (gv !== 1'b0 || go !== 4'b0000 || pend !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL flush_clear got gv=%b onehot=%b pending=%b busy=%b want 0 0000 0000 0",
                  gv, go, pend, busy);
      end
      @(negedge clk);
      total++;
      if (gv !== 1'b0 || pend !== 4'b0000) begin
         bad++;
         $display("FAIL flush_after got gv=%b pending=%b want 0 0000", gv, pend);
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      grant_ready = 1'b0; req_valid = 1'b1; req_vector = 4'b0101;
      @(negedge clk);
      req_valid = 1'b0; req_vector = '0;
      @(negedge clk);
      total++;
      if (gv !== 1'b1 || gi !== 2'd0 || pend !== 4'b0100) begin
         bad++;
         $display("FAIL async_setup got gv=%b idx=%0d pending=%b want 1 0 0100", gv, gi, pend);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (gv !== 1'b0 || go !== 4'b0000 || pend !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got gv=%b onehot=%b pending=%b busy=%b want all 0", gv, go, pend, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got no finish within time limit want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fixed_priority();
      test_backpressure();
      test_collision();
      test_round_robin();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
